// File: rtl/out_fft_fifo_pkg.sv
// out_fft_fifo_pkg
//   Shared definitions for the FFT output frame buffer:
//   - state_t  : FSM state encoding (S_FILL / S_DRAIN)
//   - MAX_AWL  : widest address the bit-reverse helper supports
//   - BIT_REV  : reverses the low 'awl' bits of an address
package out_fft_fifo_pkg;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam int MAX_AWL = 16;

  // Bits above 'awl' come back as zero. Shifting avoids any variable bit
  // index, so the loop collapses to plain wiring when 'awl' is a constant.
  function automatic logic [MAX_AWL-1:0] BIT_REV(input logic [MAX_AWL-1:0] a,
                                                 input int awl);
    logic [MAX_AWL-1:0] r;
    logic [MAX_AWL-1:0] s;
    r = '0;
    s = a;
    for (int i = 0; i < MAX_AWL; i++) begin
      if (i < awl) begin
        r = {r[MAX_AWL-2:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/out_fft_fifo_if.sv
// out_fft_fifo_if
//   Bundles the write side (pair writes from the FFT core) and the read side
//   (valid/ready sample stream) of the output frame buffer.
//   Ports (signals):
//     WR_INC, WR_DATA_1_R/I, WR_DATA_2_R/I : pair write from the core
//     WR_FULL                              : buffer is draining, writes ignored
//     O_READY                              : downstream accepts a sample
//     O_VALID, O_DATA_R/I, O_LAST          : output sample stream
//   master = producer/consumer side, slave = the buffer itself.
interface out_fft_fifo_if #(
  parameter int DWL = 16
);
  logic           WR_INC;
  logic [DWL-1:0] WR_DATA_1_R;
  logic [DWL-1:0] WR_DATA_1_I;
  logic [DWL-1:0] WR_DATA_2_R;
  logic [DWL-1:0] WR_DATA_2_I;
  logic           WR_FULL;
  logic           O_READY;
  logic           O_VALID;
  logic [DWL-1:0] O_DATA_R;
  logic [DWL-1:0] O_DATA_I;
  logic           O_LAST;

  modport master (
    output WR_INC, WR_DATA_1_R, WR_DATA_1_I, WR_DATA_2_R, WR_DATA_2_I, O_READY,
    input  WR_FULL, O_VALID, O_DATA_R, O_DATA_I, O_LAST
  );

  modport slave (
    input  WR_INC, WR_DATA_1_R, WR_DATA_1_I, WR_DATA_2_R, WR_DATA_2_I, O_READY,
    output WR_FULL, O_VALID, O_DATA_R, O_DATA_I, O_LAST
  );
endinterface

// File: rtl/out_fft_fifo_dpram.sv
// out_fft_fifo_dpram
//   Single-clock dual-port RAM, depth 2^AWL, word width W.
//   Port A: write or registered read. Port B: write.
//   Ports:
//     CLK, RST        : clock, async active-low reset (read register only)
//     we_a/addr_a/din_a, re_a/dout_a : port A
//     we_b/addr_b/din_b               : port B
//   The read register holds its value unless re_a is set, which is what keeps
//   the downstream sample stable while stalled. Array contents are not reset.
module out_fft_fifo_dpram #(
  parameter int W   = 32,
  parameter int AWL = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           we_a,
  input  logic           re_a,
  input  logic [AWL-1:0] addr_a,
  input  logic [W-1:0]   din_a,
  output logic [W-1:0]   dout_a,
  input  logic           we_b,
  input  logic [AWL-1:0] addr_b,
  input  logic [W-1:0]   din_b
);
  localparam int DEPTH = 1 << AWL;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      dout_a <= '0;
    else if (re_a) dout_a <= mem[addr_a];
  end
endmodule

// File: rtl/out_fft_fifo.sv
// out_fft_fifo
//   Output frame buffer for the iterative FFT. Collects one frame of 2^AWL
//   complex samples as even/odd pairs, then streams it out one sample per
//   cycle in natural or bit-reversed order.
//   Parameters: DWL (component width), AWL (address width),
//               BIT_REVERS_READ (1 = bit-reversed read order)
//   Ports:
//     CLK  : clock
//     RST  : async active-low reset
//     bus  : out_fft_fifo_if.slave (pair write side + sample stream side)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_FILL  | accepting pair writes; no reads
//   S_DRAIN | frame complete; streaming out, writes ignored (WR_FULL=1)
module out_fft_fifo
  import out_fft_fifo_pkg::*;
#(
  parameter int DWL             = 16,
  parameter int AWL             = 8,
  parameter int BIT_REVERS_READ = 0
) (
  input  logic           CLK,
  input  logic           RST,
  out_fft_fifo_if.slave  bus
);
  localparam int N = 1 << AWL;

  state_t           state, state_nxt;
  logic [AWL-1:0]   wr_cnt;
  logic [AWL:0]     rd_cnt;
  logic             o_valid;
  logic             o_last;

  logic             wr_acc;
  logic             wr_last_pair;
  logic             rd_en;
  logic             rd_done;
  logic [AWL-1:0]   addr_even;
  logic [AWL-1:0]   addr_odd;
  logic [AWL-1:0]   rd_addr;
  logic [AWL-1:0]   addr_a;
  logic [2*DWL-1:0] dout_a;

  assign wr_acc       = (state == S_FILL) && bus.WR_INC;
  assign wr_last_pair = (wr_cnt == AWL'(N/2 - 1));

  // A new read is issued whenever the output register is empty or being
  // emptied this cycle; rd_cnt reaching N stops issue until the frame ends.
  assign rd_en   = (state == S_DRAIN) && (rd_cnt < (AWL+1)'(N)) &&
                   (!o_valid || bus.O_READY);
  assign rd_done = o_valid && bus.O_READY && o_last;

  // wr_cnt never passes N/2-1, so dropping its MSB in the shift is lossless.
  assign addr_even = wr_cnt << 1;
  assign addr_odd  = addr_even | AWL'(1);

  assign rd_addr = (BIT_REVERS_READ != 0) ?
                   AWL'(BIT_REV(MAX_AWL'(rd_cnt[AWL-1:0]), AWL)) :
                   rd_cnt[AWL-1:0];

  // FILL and DRAIN never overlap, so port A can be shared by write and read.
  assign addr_a = (state == S_FILL) ? addr_even : rd_addr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (wr_acc && wr_last_pair) state_nxt = S_DRAIN;
      S_DRAIN: if (rd_done)                state_nxt = S_FILL;
      default:                             state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        wr_cnt <= '0;
    else if (wr_acc) wr_cnt <= wr_last_pair ? '0 : wr_cnt + AWL'(1);
  end

  // rd_done and rd_en are mutually exclusive: the last sample is issued with
  // rd_cnt = N-1, after which rd_cnt = N blocks further issue.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         rd_cnt <= '0;
    else if (rd_done) rd_cnt <= '0;
    else if (rd_en)   rd_cnt <= rd_cnt + (AWL+1)'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (rd_en) begin
      o_valid <= 1'b1;
      o_last  <= (rd_cnt == (AWL+1)'(N - 1));
    end else if (o_valid && bus.O_READY) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

  out_fft_fifo_dpram #(
    .W   (2*DWL),
    .AWL (AWL)
  ) u_ram (
    .CLK    (CLK),
    .RST    (RST),
    .we_a   (wr_acc),
    .re_a   (rd_en),
    .addr_a (addr_a),
    .din_a  ({bus.WR_DATA_1_R, bus.WR_DATA_1_I}),
    .dout_a (dout_a),
    .we_b   (wr_acc),
    .addr_b (addr_odd),
    .din_b  ({bus.WR_DATA_2_R, bus.WR_DATA_2_I})
  );

  assign bus.WR_FULL  = (state == S_DRAIN);
  assign bus.O_VALID  = o_valid;
  assign bus.O_LAST   = o_last;
  assign bus.O_DATA_R = dout_a[2*DWL-1:DWL];
  assign bus.O_DATA_I = dout_a[DWL-1:0];
endmodule

// File: tb/tb_out_fft_fifo.sv
// tb_out_fft_fifo
//   Drives a natural-order and a bit-reversed instance (AWL=3) with the same
//   stimulus. Expected samples are queued when a frame is written; one
//   monitor per instance compares every valid output cycle against the head
//   of its queue and pops on handshake.
module tb_out_fft_fifo;
  localparam int DWL = 16;
  localparam int AWL = 3;
  localparam int N   = 1 << AWL;

  typedef struct packed {
    logic [DWL-1:0] r;
    logic [DWL-1:0] i;
    logic           last;
  } samp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic           wr_inc  = 1'b0;
  logic [DWL-1:0] d1r     = '0;
  logic [DWL-1:0] d1i     = '0;
  logic [DWL-1:0] d2r     = '0;
  logic [DWL-1:0] d2i     = '0;
  logic           o_ready = 1'b1;

  out_fft_fifo_if #(.DWL(DWL)) if_nat ();
  out_fft_fifo_if #(.DWL(DWL)) if_rev ();

  assign if_nat.WR_INC = wr_inc;  assign if_rev.WR_INC = wr_inc;
  assign if_nat.WR_DATA_1_R = d1r; assign if_rev.WR_DATA_1_R = d1r;
  assign if_nat.WR_DATA_1_I = d1i; assign if_rev.WR_DATA_1_I = d1i;
  assign if_nat.WR_DATA_2_R = d2r; assign if_rev.WR_DATA_2_R = d2r;
  assign if_nat.WR_DATA_2_I = d2i; assign if_rev.WR_DATA_2_I = d2i;
  assign if_nat.O_READY = o_ready; assign if_rev.O_READY = o_ready;

  out_fft_fifo #(.DWL(DWL), .AWL(AWL), .BIT_REVERS_READ(0)) u_nat (
    .CLK (CLK), .RST (RST), .bus (if_nat));
  out_fft_fifo #(.DWL(DWL), .AWL(AWL), .BIT_REVERS_READ(1)) u_rev (
    .CLK (CLK), .RST (RST), .bus (if_rev));

  samp_t exp_nat[$];
  samp_t exp_rev[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    rev3[N]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int    bp_pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitors: compare on every valid cycle, including stalls, so a sample
  // that changes while O_READY=0 is caught against the unpopped head.
  always @(negedge CLK) begin
    if (RST && if_nat.O_VALID) begin
      if (exp_nat.size() == 0) chk("nat_unexpected_valid", 1, 0);
      else begin
        chk("nat_sample", {if_nat.O_DATA_R, if_nat.O_DATA_I, if_nat.O_LAST}, exp_nat[0]);
        if (o_ready) void'(exp_nat.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (RST && if_rev.O_VALID) begin
      if (exp_rev.size() == 0) chk("rev_unexpected_valid", 1, 0);
      else begin
        chk("rev_sample", {if_rev.O_DATA_R, if_rev.O_DATA_I, if_rev.O_LAST}, exp_rev[0]);
        if (o_ready) void'(exp_rev.pop_front());
      end
    end
  end

  // Sample index k of a frame carries R = base+k, I = -(base+k).
  task automatic push_frame(input int base);
    samp_t s;
    for (int j = 0; j < N; j++) begin
      s.r = 16'(base + j); s.i = 16'(-(base + j)); s.last = (j == N-1);
      exp_nat.push_back(s);
      s.r = 16'(base + rev3[j]); s.i = 16'(-(base + rev3[j])); s.last = (j == N-1);
      exp_rev.push_back(s);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the
  // last pair.
  task automatic write_frame(input int base);
    for (int p = 0; p < N/2; p++) begin
      wr_inc = 1'b1;
      d1r = 16'(base + 2*p);     d1i = 16'(-(base + 2*p));
      d2r = 16'(base + 2*p + 1); d2i = 16'(-(base + 2*p + 1));
      @(posedge CLK); #1;
    end
    wr_inc = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int cyc = 0;
    while (if_nat.WR_FULL && cyc < 200) begin
      @(posedge CLK); #1; cyc++;
    end
    chk({name, "_timeout"}, if_nat.WR_FULL, 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_nat_valid"}, if_nat.O_VALID, 0);
    chk({name, "_nat_last"},  if_nat.O_LAST, 0);
    chk({name, "_nat_data"},  {if_nat.O_DATA_R, if_nat.O_DATA_I}, 0);
    chk({name, "_nat_full"},  if_nat.WR_FULL, 0);
    chk({name, "_rev_valid"}, if_rev.O_VALID, 0);
    chk({name, "_rev_full"},  if_rev.WR_FULL, 0);
  endtask

  initial begin
    int cyc;
    #2;
    chk_reset_outputs("por");
    @(posedge CLK); #1;
    RST = 1'b1;
    o_ready = 1'b1;

    // Natural / bit-reversed order, O_READY held high.
    push_frame(0);
    write_frame(0);
    chk("t1_valid_after_last_pair", if_nat.O_VALID, 0);
    chk("t1_full_nat", if_nat.WR_FULL, 1);
    chk("t1_full_rev", if_rev.WR_FULL, 1);
    for (int k = 0; k < N; k++) begin
      @(posedge CLK); #1;
      chk("t1_nat_valid_run", if_nat.O_VALID, 1);
      chk("t1_rev_valid_run", if_rev.O_VALID, 1);
      chk("t1_full_during_drain", if_nat.WR_FULL, 1);
    end
    @(posedge CLK); #1;
    chk("t1_valid_after_frame", if_nat.O_VALID, 0);
    chk("t1_full_after_frame", if_nat.WR_FULL, 0);
    chk("t1_nat_queue_empty", exp_nat.size(), 0);
    chk("t1_rev_queue_empty", exp_rev.size(), 0);

    // Backpressure.
    push_frame(16);
    write_frame(16);
    cyc = 0;
    while (if_nat.WR_FULL && cyc < 200) begin
      o_ready = bp_pat[cyc % 6][0];
      @(posedge CLK); #1; cyc++;
    end
    chk("t2_timeout", if_nat.WR_FULL, 0);
    o_ready = 1'b1;
    chk("t2_nat_queue_empty", exp_nat.size(), 0);
    chk("t2_rev_queue_empty", exp_rev.size(), 0);

    // Writes during drain are ignored; the first pair after the final
    // handshake starts the next frame at address 0.
    push_frame(48);
    write_frame(48);
    wr_inc = 1'b1; d1r = 16'hAAAA; d1i = 16'hAAAA; d2r = 16'hAAAA; d2i = 16'hAAAA;
    wait_drained("t3_drain");
    push_frame(64);
    write_frame(64);
    wait_drained("t3_next");
    chk("t3_nat_queue_empty", exp_nat.size(), 0);
    chk("t3_rev_queue_empty", exp_rev.size(), 0);

    // Reset mid-drain after three outputs.
    push_frame(80);
    write_frame(80);
    cyc = 0;
    while (exp_nat.size() > N-3 && cyc < 50) begin
      @(posedge CLK); #1; cyc++;
    end
    chk("t4_three_out_timeout", exp_nat.size(), N-3);
    wr_inc  = 1'(($urandom_range(0, 1)));
    o_ready = 1'(($urandom_range(0, 1)));
    d1r = 16'($urandom); d1i = 16'($urandom); d2r = 16'($urandom); d2i = 16'($urandom);
    RST = 1'b0;
    #1;
    chk_reset_outputs("t4_mid_reset");
    exp_nat.delete();
    exp_rev.delete();
    @(posedge CLK); #1;
    wr_inc  = 1'b0;
    o_ready = 1'b1;
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("t4_no_stale_valid", if_nat.O_VALID | if_rev.O_VALID, 0);
    end
    push_frame(96);
    write_frame(96);
    wait_drained("t4_refill");
    chk("t4_nat_queue_empty", exp_nat.size(), 0);
    chk("t4_rev_queue_empty", exp_rev.size(), 0);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/out_fft_fifo.md
# out_fft_fifo

Output frame buffer for the iterative FFT. It accepts butterfly results from the FFT core two complex samples per cycle, writing each pair to adjacent even/odd addresses. Once a full frame of 2^AWL samples is held, it streams the frame out one complex sample per cycle under a valid/ready handshake, in natural or bit-reversed address order. It is the drain-side counterpart of the FFT input FIFO: pair writes in, single-sample reads out.

## Interface
- DWL, 16, width of each real/imaginary component
- AWL, 8, address width; frame length N = 2^AWL, AWL >= 2
- BIT_REVERS_READ, 0, 1 = read address is bit-reversed read count; 0 = natural order

- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  asynchronous, active-low reset
- WR_INC  in  1  pair write strobe
- WR_DATA_1_R / WR_DATA_1_I  in  DWL each  sample for even address
- WR_DATA_2_R / WR_DATA_2_I  in  DWL each  sample for odd address
- WR_FULL  out  1  buffer not accepting writes (state DRAIN)
- O_READY  in  1  downstream accepts sample
- O_VALID  out  1  O_DATA_R/I valid
- O_DATA_R / O_DATA_I  out  DWL each  output sample
- O_LAST  out  1  qualifies final sample of frame (only meaningful with O_VALID)

## Operation
- FSM states: FILL (reset state), DRAIN.
- FILL: a write is accepted when WR_INC=1. Sample 1 goes to address 2*p; sample 2 goes to 2*p+1; p = wr_cnt. wr_cnt is AWL bits and increments per accepted pair.
- On the edge accepting pair N/2-1: wr_cnt wraps to 0, state <= DRAIN.
- DRAIN: WR_INC is ignored with no memory write and no counter change. WR_FULL=1 combinationally from state.
- Read issue: rd_en = DRAIN && rd_cnt < N && (!O_VALID || O_READY). rd_cnt is AWL+1 bits.
- Read address = rd_cnt[AWL-1:0], bit-reversed when BIT_REVERS_READ=1.
- On rd_en the RAM read register loads. On that same edge:
  - O_VALID <= 1
  - O_LAST <= (rd_cnt == N-1)
  - rd_cnt++
- Otherwise, if O_VALID && O_READY: O_VALID <= 0 and O_LAST <= 0.
- While O_VALID && !O_READY, O_DATA and O_LAST hold stable.
- On handshake with O_LAST=1: state <= FILL, rd_cnt <= 0, O_VALID/O_LAST <= 0 (unless reissued, which cannot occur since rd_cnt = N).
- FILL and DRAIN are exclusive, so no read/write address collision is possible.

## Timing
- Reset (RST=0, asynchronous): state=FILL, wr_cnt=0, rd_cnt=0. O_VALID=0, O_LAST=0, O_DATA_R/I=0, WR_FULL=0.
- RAM contents are not cleared by reset.
- Write-to-memory latency is 1 edge.
- Last pair accepted at edge k: WR_FULL=1 from after edge k. rd_en is high in cycle k+1. O_VALID=1 after edge k+1, i.e. 2 edges after the last write.
- Read latency is 1 cycle (RAM output register drives O_DATA directly, no extra pipeline).
- Throughput is 1 sample/cycle with O_READY held high. A frame drains in N consecutive valid cycles.
- Final handshake at edge m: WR_FULL=0 after edge m, and a pair write is accepted at edge m+1.
- Reset asserted mid-frame: any partial frame is discarded. The next frame starts at address 0 in FILL.

## Structure
- Package out_fft_fifo_pkg holds:
  - state encoding constants S_FILL/S_DRAIN
  - BIT_REV function parameterised by AWL
- Sub-module out_fft_fifo_dpram: true dual-port, single-clock RAM, word width 2*DWL ({R,I} packed), depth 2^AWL, synchronous read with output register.
  - FILL: port A writes the even address, port B writes the odd address.
  - DRAIN: port A reads.
- Top level contains the FSM, both counters, the address mux and the valid/last logic.

## Test plan
- Reset: drive RST=0 mid-simulation with random inputs -> O_VALID=0, O_LAST=0, O_DATA=0, WR_FULL=0 immediately, with no clock edge needed.
- Natural order, AWL=3, BIT_REVERS_READ=0, O_READY=1: write pairs (0,1),(2,3),(4,5),(6,7), with R = index and I = -index -> O_VALID 2 edges after the last pair. Outputs 0..7 on consecutive cycles, O_LAST only on 7, WR_FULL=1 during drain.
- Bit-reversed order: same stimulus with BIT_REVERS_READ=1 -> output order 0,4,2,6,1,5,3,7, with O_LAST on 7.
- Backpressure: O_READY pattern 1,0,0,1,0,1,... -> every index appears exactly once, in order. O_DATA and O_LAST stay stable across stall cycles.
- Writes during DRAIN: WR_INC=1 with data 0xAAAA throughout the drain -> output unaffected and no counter change. The first pair after the final handshake lands at addresses 0/1 and appears first in the next frame.
- Reset mid-drain: assert RST after 3 outputs, then refill with new data -> the new frame outputs from index 0 with the new values, and no stale O_VALID is seen.
